// File: rtl/iqueue_mp_pkg.sv
// rtl/iqueue_mp_pkg.sv - shared defaults and helpers for the multi-lane instruction queue
// Purpose: default geometry of the IF->ID instruction queue and a constant clog2 helper.
// Ports: none (package).
package iqueue_mp_pkg;

  localparam int IQ_DEPTH_DEF   = 32;
  localparam int IQ_LANES_DEF   = 2;
  localparam int IQ_INSTR_W_DEF = 32;
  localparam int IQ_PC_W_DEF    = 32;

  // Constant-foldable ceil(log2(value)); value <= 1 yields 0.
  function automatic int iq_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/iqueue_mp_if.sv
// rtl/iqueue_mp_if.sv - IF/ID-facing bundle of the multi-lane instruction queue
// Purpose: groups control, push (IF side) and head/pop (ID side) signals.
// Ports (by modport):
//   master: drives rdy_i, clr_i, push_cnt_i, push_data_i, push_pc_i, pop_cnt_i;
//           observes free_o, full_o, count_o, head_vld_o, head_data_o, head_pc_o
//   slave : the queue itself, opposite directions
interface iqueue_mp_if
  import iqueue_mp_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH_DEF,
  parameter int DATA_W = IQ_INSTR_W_DEF,
  parameter int PC_W   = IQ_PC_W_DEF,
  parameter int LANES  = IQ_LANES_DEF
) ();

  localparam int PTR_W  = iq_clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LCNT_W = iq_clog2(LANES + 1);

  logic                    rdy_i;
  logic                    clr_i;
  logic [LCNT_W-1:0]       push_cnt_i;
  logic [LANES*DATA_W-1:0] push_data_i;
  logic [LANES*PC_W-1:0]   push_pc_i;
  logic [CNT_W-1:0]        free_o;
  logic                    full_o;
  logic [LCNT_W-1:0]       pop_cnt_i;
  logic [LANES-1:0]        head_vld_o;
  logic [LANES*DATA_W-1:0] head_data_o;
  logic [LANES*PC_W-1:0]   head_pc_o;
  logic [CNT_W-1:0]        count_o;

  modport master (
    output rdy_i, clr_i, push_cnt_i, push_data_i, push_pc_i, pop_cnt_i,
    input  free_o, full_o, head_vld_o, head_data_o, head_pc_o, count_o
  );

  modport slave (
    input  rdy_i, clr_i, push_cnt_i, push_data_i, push_pc_i, pop_cnt_i,
    output free_o, full_o, head_vld_o, head_data_o, head_pc_o, count_o
  );

endinterface

// File: rtl/iq_lane_mux.sv
// rtl/iq_lane_mux.sv - read/forward selector for one head lane of the instruction queue
// Purpose: lane LANE shows stored entry head+LANE; with IQ_BYPASS_EN defined, a lane past
//          the stored occupancy forwards push lane (LANE - count) in the same cycle.
// Ports: count (stored occupancy), mem_data/mem_pc (stored entry head+LANE),
//        push_cnt/push_data/push_pc (only with IQ_BYPASS_EN), vld/data/pc (lane output).
// Macro: IQ_BYPASS_EN enables same-cycle forwarding.
module iq_lane_mux
  import iqueue_mp_pkg::*;
#(
  parameter int LANE   = 0,
  parameter int LANES  = IQ_LANES_DEF,
  parameter int DATA_W = IQ_INSTR_W_DEF,
  parameter int PC_W   = IQ_PC_W_DEF,
  parameter int CNT_W  = 6
) (
  input  logic [CNT_W-1:0]        count,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic [PC_W-1:0]         mem_pc,
`ifdef IQ_BYPASS_EN
  input  logic [CNT_W-1:0]        push_cnt,
  input  logic [LANES*DATA_W-1:0] push_data,
  input  logic [LANES*PC_W-1:0]   push_pc,
`endif
  output logic                    vld,
  output logic [DATA_W-1:0]       data,
  output logic [PC_W-1:0]         pc
);

`ifdef IQ_BYPASS_EN
  logic [CNT_W-1:0] fwd_idx;
`endif

  always_comb begin
    vld  = CNT_W'(LANE) < count;
    data = mem_data;
    pc   = mem_pc;
`ifdef IQ_BYPASS_EN
    // Only meaningful when LANE >= count, which is exactly when vld is still 0.
    fwd_idx = CNT_W'(LANE) - count;
    if (!vld) begin
      vld = fwd_idx < push_cnt;
      for (int j = 0; j < LANES; j++) begin
        if (fwd_idx == CNT_W'(j)) begin
          data = push_data[j*DATA_W +: DATA_W];
          pc   = push_pc[j*PC_W +: PC_W];
        end
      end
    end
`endif
  end

endmodule

// File: rtl/iqueue_mp.sv
// rtl/iqueue_mp.sv - multi-lane instruction queue between IF and ID
// Purpose: accepts up to LANES {instr,pc} pairs per cycle, presents the oldest LANES entries,
//          retires 0..LANES per cycle; registered count/free/full credit.
// Ports: clk, rst_n (async active-low), bus (iqueue_mp_if.slave: rdy_i, clr_i, push_*,
//        pop_cnt_i, free_o, full_o, count_o, head_vld_o, head_data_o, head_pc_o).
// Macro: IQ_BYPASS_EN adds same-cycle push-to-head forwarding while count < LANES.
module iqueue_mp
  import iqueue_mp_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH_DEF,
  parameter int DATA_W = IQ_INSTR_W_DEF,
  parameter int PC_W   = IQ_PC_W_DEF,
  parameter int LANES  = IQ_LANES_DEF
) (
  input logic        clk,
  input logic        rst_n,
  iqueue_mp_if.slave bus
);

  localparam int PTR_W = iq_clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, free_q;
  logic              full_q;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];

  logic [CNT_W-1:0]  push_req, pop_req, push_eff, pop_eff, pop_fwd, pop_mem, avail;
  logic [CNT_W-1:0]  count_nxt, free_nxt;
  logic [LANES-1:0]  wr_en;
  logic [PTR_W-1:0]  wr_addr [LANES];
  logic [PTR_W-1:0]  rd_addr [LANES];

  always_comb begin
    push_req = CNT_W'(bus.push_cnt_i);
    pop_req  = CNT_W'(bus.pop_cnt_i);
    // Illegal requests are clipped so the pointers can never overrun each other.
    push_eff = (push_req > free_q) ? free_q : push_req;
`ifdef IQ_BYPASS_EN
    avail    = count_q + push_eff;
`else
    avail    = count_q;
`endif
    if (avail > CNT_W'(LANES)) avail = CNT_W'(LANES);
    pop_eff  = (pop_req > avail) ? avail : pop_req;
`ifdef IQ_BYPASS_EN
    // Pops beyond the stored entries consume forwarded push lanes, which are never written.
    pop_fwd  = (pop_eff > count_q) ? pop_eff - count_q : '0;
`else
    pop_fwd  = '0;
`endif
    pop_mem   = pop_eff - pop_fwd;
    count_nxt = count_q + push_eff - pop_eff;
    free_nxt  = CNT_W'(DEPTH) - count_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= CNT_W'(DEPTH);
      full_q  <= 1'b0;
    end else if (bus.rdy_i) begin
      if (bus.clr_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        free_q  <= CNT_W'(DEPTH);
        full_q  <= 1'b0;
      end else begin
        head_q  <= head_q + PTR_W'(pop_mem);
        tail_q  <= tail_q + PTR_W'(push_eff - pop_fwd);
        count_q <= count_nxt;
        free_q  <= free_nxt;
        full_q  <= free_nxt < CNT_W'(LANES);
      end
    end
  end

  // Forwarded-and-popped lanes are skipped, so surviving lanes pack from tail.
  for (genvar k = 0; k < LANES; k++) begin : g_wr
    assign wr_en[k]   = bus.rdy_i && !bus.clr_i &&
                        (CNT_W'(k) >= pop_fwd) && (CNT_W'(k) < push_eff);
    assign wr_addr[k] = tail_q + PTR_W'(CNT_W'(k) - pop_fwd);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_en[k]) begin
        mem_data[wr_addr[k]] <= bus.push_data_i[k*DATA_W +: DATA_W];
        mem_pc[wr_addr[k]]   <= bus.push_pc_i[k*PC_W +: PC_W];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_head
    assign rd_addr[k] = head_q + PTR_W'(k);
    iq_lane_mux #(
      .LANE(k), .LANES(LANES), .DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)
    ) u_lane_mux (
      .count    (count_q),
      .mem_data (mem_data[rd_addr[k]]),
      .mem_pc   (mem_pc[rd_addr[k]]),
`ifdef IQ_BYPASS_EN
      .push_cnt (push_eff),
      .push_data(bus.push_data_i),
      .push_pc  (bus.push_pc_i),
`endif
      .vld      (bus.head_vld_o[k]),
      .data     (bus.head_data_o[k*DATA_W +: DATA_W]),
      .pc       (bus.head_pc_o[k*PC_W +: PC_W])
    );
  end

  assign bus.count_o = count_q;
  assign bus.free_o  = free_q;
  assign bus.full_o  = full_q;

  always @(posedge clk) begin
    if (rst_n && bus.rdy_i && !bus.clr_i) begin
      assert (push_req <= free_q) else $error("iqueue_mp: push_cnt exceeds free slots");
      assert (pop_req <= avail) else $error("iqueue_mp: pop_cnt exceeds valid head lanes");
    end
  end

endmodule

// File: tb/tb_iqueue_mp.sv
// tb/tb_iqueue_mp.sv - self-checking bench for iqueue_mp against a queue-based reference
module tb_iqueue_mp;

  localparam int DEPTH  = 32;
  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int LCNT_W = $clog2(LANES + 1);

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [63:0] model_q[$];

  iqueue_mp_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W), .LANES(LANES)) bus ();

  iqueue_mp #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W), .LANES(LANES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Compare every visible output against the model; pushed lanes are visible this cycle only with bypass.
  task automatic check_outputs(input logic [63:0] lanes[$], input int pn);
    logic [63:0]      vis[$];
    int               nv;
    logic [LANES-1:0] exp_vld;
    vis = model_q;
`ifdef IQ_BYPASS_EN
    for (int j = 0; j < pn; j++) vis.push_back(lanes[j]);
`endif
    nv = min2(vis.size(), LANES);
    exp_vld = '0;
    for (int k = 0; k < nv; k++) exp_vld[k] = 1'b1;
    chk("count", 64'(bus.count_o), 64'(model_q.size()));
    chk("free", 64'(bus.free_o), 64'(DEPTH - model_q.size()));
    chk("full", 64'(bus.full_o), 64'((DEPTH - model_q.size()) < LANES));
    chk("head_vld", 64'(bus.head_vld_o), 64'(exp_vld));
    for (int k = 0; k < nv; k++) begin
      chk("head_data", 64'(bus.head_data_o[k*DATA_W +: DATA_W]), 64'(vis[k][63:32]));
      chk("head_pc", 64'(bus.head_pc_o[k*PC_W +: PC_W]), 64'(vis[k][31:0]));
    end
  endtask

  task automatic cycle(input int pn, input int popn, input bit rdy, input bit clr);
    logic [63:0] lanes[$];
    logic [31:0] d, p;
    @(negedge clk);
    bus.rdy_i      = rdy;
    bus.clr_i      = clr;
    bus.push_cnt_i = LCNT_W'(pn);
    bus.pop_cnt_i  = LCNT_W'(popn);
    for (int k = 0; k < LANES; k++) begin
      d = $urandom;
      p = $urandom;
      lanes.push_back({d, p});
      bus.push_data_i[k*DATA_W +: DATA_W] = d;
      bus.push_pc_i[k*PC_W +: PC_W]       = p;
    end
    #1;
    check_outputs(lanes, pn);
    @(posedge clk);
    if (rdy) begin
      if (clr) model_q.delete();
      else begin
        for (int j = 0; j < pn; j++) model_q.push_back(lanes[j]);
        for (int j = 0; j < popn; j++) void'(model_q.pop_front());
      end
    end
  endtask

  function automatic int max_push();
    return min2(LANES, DEPTH - model_q.size());
  endfunction

  function automatic int max_pop(input int pn);
`ifdef IQ_BYPASS_EN
    return min2(LANES, model_q.size() + pn);
`else
    return min2(LANES, model_q.size());
`endif
  endfunction

  initial begin
    int pn, popn;
    bit rdy, clr;
    checks   = 0;
    failures = 0;
    rst_n          = 1'b0;
    bus.rdy_i      = 1'b1;
    bus.clr_i      = 1'b0;
    bus.push_cnt_i = '0;
    bus.pop_cnt_i  = '0;
    bus.push_data_i = '0;
    bus.push_pc_i   = '0;
    #12;
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_free", 64'(bus.free_o), 64'(DEPTH));
    chk("rst_full", 64'(bus.full_o), 64'd0);
    chk("rst_vld", 64'(bus.head_vld_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Push A,B then observe them at the head.
    cycle(2, 0, 1, 0);
    cycle(0, 0, 1, 0);

    // Fill to DEPTH two per cycle, then confirm the boundary explicitly.
    while (model_q.size() < DEPTH) cycle(2, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("fill_count", 64'(bus.count_o), 64'(DEPTH));
    chk("fill_free", 64'(bus.free_o), 64'd0);
    chk("fill_full", 64'(bus.full_o), 64'd1);

    // Drain in order.
    while (model_q.size() > 0) cycle(0, 2, 1, 0);

    // Hold five entries under steady push 2 / pop 2 so pointers wrap.
    cycle(2, 0, 1, 0);
    cycle(2, 0, 1, 0);
    cycle(1, 0, 1, 0);
    for (int i = 0; i < 40; i++) cycle(2, 2, 1, 0);

    // Flush with a push in the same cycle at count 7.
    cycle(2, 0, 1, 0);
    cycle(2, 2, 1, 1);
    cycle(0, 0, 1, 0);
    chk("clr_count", 64'(bus.count_o), 64'd0);
    chk("clr_vld", 64'(bus.head_vld_o), 64'd0);

    // Freeze for three cycles with traffic driven.
    cycle(2, 0, 1, 0);
    cycle(2, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(2, 1, 0, 0);
    cycle(0, 0, 1, 0);
    chk("frz_count", 64'(bus.count_o), 64'd4);

`ifdef IQ_BYPASS_EN
    // Empty queue: pushed lane 0 is visible and popped in the same cycle.
    cycle(0, 0, 1, 1);
    cycle(2, 1, 1, 0);
    cycle(0, 0, 1, 0);
    chk("byp_count", 64'(bus.count_o), 64'd1);
`endif

    // Asynchronous reset mid-cycle empties the queue without a clock edge.
    @(negedge clk);
    bus.push_cnt_i = '0;
    bus.pop_cnt_i  = '0;
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    chk("arst_count", 64'(bus.count_o), 64'd0);
    chk("arst_free", 64'(bus.free_o), 64'(DEPTH));
    chk("arst_vld", 64'(bus.head_vld_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized legal traffic with occasional freeze and flush.
    for (int i = 0; i < 400; i++) begin
      rdy  = ($urandom_range(0, 7) != 0);
      clr  = ($urandom_range(0, 49) == 0);
      pn   = $urandom_range(0, max_push());
      popn = $urandom_range(0, max_pop(pn));
      cycle(pn, popn, rdy, clr);
    end
    cycle(0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
